// File: rtl/biu_arbiter_if.sv
// Bus bundle between the two masters, the biu_arbiter and the SDRAM biu.
// The arbiter uses the slave view; masters, biu and benches use the master view.
interface biu_arbiter_if;
  logic        M0Req,   M1Req;
  logic [31:0] M0Addr,  M1Addr;
  logic [31:0] M0Data,  M1Data;
  logic [8:0]  M0Ctrl,  M1Ctrl;
  logic        M0Gnt,   M1Gnt;
  logic        M0Ready, M1Ready;
  logic        BiuReady;
  logic [31:0] BiuAddr, BiuData;
  logic [8:0]  BiuCtrl;
  logic        BiuEn;
  logic        WdogErr;

  modport slave (
    input  M0Req, M1Req, M0Addr, M1Addr, M0Data, M1Data, M0Ctrl, M1Ctrl, BiuReady,
    output M0Gnt, M1Gnt, M0Ready, M1Ready, BiuAddr, BiuData, BiuCtrl, BiuEn, WdogErr
  );

  modport master (
    output M0Req, M1Req, M0Addr, M1Addr, M0Data, M1Data, M0Ctrl, M1Ctrl, BiuReady,
    input  M0Gnt, M1Gnt, M0Ready, M1Ready, BiuAddr, BiuData, BiuCtrl, BiuEn, WdogErr
  );
endinterface

// File: rtl/biu_arbiter.sv
// Round-robin arbiter sharing the SDRAM biu between two masters; grant held per transfer.
// Optional owner watchdog enabled by defining ARB_WDOG_EN.
module biu_arbiter #(
  parameter int unsigned WDOG_CYCLES = 64,
  parameter int unsigned WDOG_W      = 8
) (
  input logic          Clk,
  input logic          Rst,
  biu_arbiter_if.slave bus
);
  localparam logic [1:0] ST_IDLE   = 2'b10;
  localparam logic [8:0] CTRL_IDLE = {ST_IDLE, 7'b0};

  typedef enum logic [1:0] {ARB_IDLE, ARB_OWN, ARB_DRAIN, ARB_HANDOVER} arb_state_t;

  arb_state_t  state, state_nx;
  logic        owner, owner_nx;
  logic        rr, rr_nx;
  logic [1:0]  gnt, gnt_nx;
  logic [31:0] hold_addr, hold_data;
  logic [8:0]  hold_ctrl;
  logic [31:0] own_addr, own_data;
  logic [8:0]  own_ctrl;
  logic        own_req;
  logic [1:0]  req, elig;
  logic        wdog_fire;
  logic        serving;

  assign req      = {bus.M1Req, bus.M0Req};
  assign own_req  = owner ? bus.M1Req  : bus.M0Req;
  assign own_addr = owner ? bus.M1Addr : bus.M0Addr;
  assign own_data = owner ? bus.M1Data : bus.M0Data;
  assign own_ctrl = owner ? bus.M1Ctrl : bus.M0Ctrl;

`ifdef ARB_WDOG_EN
  logic [WDOG_W-1:0] wdog_cnt;
  logic              wdog_err;
  logic [1:0]        blk;
  logic [1:0]        fire_vec;

  // Status S_IDLE/S_BUSY both have bit 8 set; only those cycles age the owner.
  assign wdog_fire = (state == ARB_OWN) && own_req && own_ctrl[8] &&
                     (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
  assign fire_vec  = wdog_fire ? (owner ? 2'b10 : 2'b01) : 2'b00;
  // A master cut off by the watchdog stays ineligible until it drops Req once.
  assign elig      = req & ~blk;
  assign bus.WdogErr = wdog_err;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      wdog_cnt <= '0;
      wdog_err <= 1'b0;
      blk      <= '0;
    end else begin
      if ((state == ARB_OWN) && own_ctrl[8] && !wdog_fire)
        wdog_cnt <= wdog_cnt + 1'b1;
      else
        wdog_cnt <= '0;
      wdog_err <= wdog_err | wdog_fire;
      blk      <= (blk | fire_vec) & req;
    end
  end
`else
  assign wdog_fire   = 1'b0;
  assign elig        = req;
  assign bus.WdogErr = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    owner_nx = owner;
    rr_nx    = rr;
    gnt_nx   = gnt;
    unique case (state)
      ARB_IDLE: begin
        if (|elig) begin
          owner_nx = (elig == 2'b11) ? rr : elig[1];
          gnt_nx   = owner_nx ? 2'b10 : 2'b01;
          state_nx = ARB_OWN;
        end
      end
      ARB_OWN: begin
        if (!own_req) begin
          gnt_nx   = '0;
          state_nx = bus.BiuReady ? ARB_HANDOVER : ARB_DRAIN;
        end else if (wdog_fire) begin
          gnt_nx   = '0;
          state_nx = ARB_DRAIN;
        end
      end
      ARB_DRAIN: begin
        if (bus.BiuReady) state_nx = ARB_HANDOVER;
      end
      ARB_HANDOVER: begin
        rr_nx    = ~owner;
        state_nx = ARB_IDLE;
      end
      default: state_nx = ARB_IDLE;
    endcase
  end

  always_comb begin
    bus.BiuAddr = '0;
    bus.BiuData = '0;
    bus.BiuCtrl = CTRL_IDLE;
    bus.BiuEn   = 1'b0;
    unique case (state)
      ARB_OWN: begin
        bus.BiuAddr = own_addr;
        bus.BiuData = own_data;
        bus.BiuCtrl = own_ctrl;
        bus.BiuEn   = 1'b1;
      end
      ARB_DRAIN: begin
        bus.BiuAddr = hold_addr;
        bus.BiuData = hold_data;
        bus.BiuCtrl = {ST_IDLE, hold_ctrl[6:0]};
        bus.BiuEn   = 1'b1;
      end
      default: ;
    endcase
  end

  assign serving     = (state == ARB_OWN) || (state == ARB_DRAIN);
  assign bus.M0Ready = bus.BiuReady && serving && !owner;
  assign bus.M1Ready = bus.BiuReady && serving &&  owner;
  assign bus.M0Gnt   = gnt[0];
  assign bus.M1Gnt   = gnt[1];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= ARB_IDLE;
      owner     <= 1'b0;
      rr        <= 1'b0;
      gnt       <= '0;
      hold_addr <= '0;
      hold_data <= '0;
      hold_ctrl <= CTRL_IDLE;
    end else begin
      state <= state_nx;
      owner <= owner_nx;
      rr    <= rr_nx;
      gnt   <= gnt_nx;
      if (state == ARB_OWN) begin
        hold_addr <= own_addr;
        hold_data <= own_data;
        hold_ctrl <= own_ctrl;
      end
    end
  end

  a_gnt_onehot: assert property (@(posedge Clk) disable iff (Rst) gnt != 2'b11);
endmodule

// File: tb/tb_biu_arbiter.sv
// Directed-vector bench for biu_arbiter: table of per-cycle expectations plus
// hand-written reset, fairness and watchdog/hold sequences.
module tb_biu_arbiter;
  localparam logic [31:0] A0 = 32'h0000_4AD0;
  localparam logic [31:0] D0 = 32'hA0A0_0000;
  localparam logic [31:0] A1 = 32'h1111_2220;
  localparam logic [31:0] D1 = 32'hB1B1_0001;
  localparam int NV = 18;

  typedef struct {
    logic       m0req, m1req;
    logic [8:0] m0ctrl, m1ctrl;
    logic       rdy;
    logic       g0, g1, r0, r1, en;
    logic [8:0] ctrl;
    logic [31:0] addr, data;
  } vec_t;

  logic Clk;
  logic Rst;
  int   checks;
  int   failures;
  vec_t tbl [NV];

  biu_arbiter_if bus ();

  biu_arbiter #(.WDOG_CYCLES(8), .WDOG_W(8)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    bus.M0Req = 1'b0;
    bus.M1Req = 1'b0;
    bus.BiuReady = 1'b0;
    step();
    Rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    Rst = 1'b1;
    bus.M0Req = 1'b0;    bus.M1Req = 1'b0;
    bus.M0Addr = A0;     bus.M1Addr = A1;
    bus.M0Data = D0;     bus.M1Data = D1;
    bus.M0Ctrl = 9'h025; bus.M1Ctrl = 9'h00C;
    bus.BiuReady = 1'b0;

    // rows: m0req m1req m0ctrl m1ctrl rdy | g0 g1 r0 r1 en ctrl addr data
    tbl[0]  = '{1'b0, 1'b0, 9'h025, 9'h00C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h100, 32'h0, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 9'h025, 9'h00C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h100, 32'h0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 9'h025, 9'h00C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h025, A0, D0};
    tbl[3]  = '{1'b1, 1'b1, 9'h0A5, 9'h00C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 9'h0A5, A0, D0};
    tbl[4]  = '{1'b0, 1'b1, 9'h0A5, 9'h00C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h0A5, A0, D0};
    for (int i = 5; i < 10; i++)
      tbl[i] = '{1'b0, 1'b1, 9'h1FF, 9'h00C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 9'h125, A0, D0};
    tbl[10] = '{1'b0, 1'b1, 9'h1FF, 9'h00C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 9'h125, A0, D0};
    tbl[11] = '{1'b0, 1'b1, 9'h025, 9'h00C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h100, 32'h0, 32'h0};
    tbl[12] = '{1'b0, 1'b1, 9'h025, 9'h00C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h100, 32'h0, 32'h0};
    tbl[13] = '{1'b1, 1'b1, 9'h025, 9'h00C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 9'h00C, A1, D1};
    tbl[14] = '{1'b1, 1'b0, 9'h025, 9'h08C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 9'h08C, A1, D1};
    tbl[15] = '{1'b1, 1'b0, 9'h025, 9'h08C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h100, 32'h0, 32'h0};
    tbl[16] = '{1'b1, 1'b0, 9'h025, 9'h08C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h100, 32'h0, 32'h0};
    tbl[17] = '{1'b1, 1'b0, 9'h0A5, 9'h08C, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 9'h0A5, A0, D0};

    step();
    step();
    Rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      bus.M0Req = tbl[i].m0req;   bus.M1Req = tbl[i].m1req;
      bus.M0Ctrl = tbl[i].m0ctrl; bus.M1Ctrl = tbl[i].m1ctrl;
      bus.BiuReady = tbl[i].rdy;
      #1;
      chk($sformatf("row%0d m0gnt", i),   bus.M0Gnt,   tbl[i].g0);
      chk($sformatf("row%0d m1gnt", i),   bus.M1Gnt,   tbl[i].g1);
      chk($sformatf("row%0d m0ready", i), bus.M0Ready, tbl[i].r0);
      chk($sformatf("row%0d m1ready", i), bus.M1Ready, tbl[i].r1);
      chk($sformatf("row%0d biuen", i),   bus.BiuEn,   tbl[i].en);
      chk($sformatf("row%0d biuctrl", i), bus.BiuCtrl, tbl[i].ctrl);
      chk($sformatf("row%0d biuaddr", i), bus.BiuAddr, tbl[i].addr);
      chk($sformatf("row%0d biudata", i), bus.BiuData, tbl[i].data);
      chk($sformatf("row%0d wdogerr", i), bus.WdogErr, 1'b0);
      step();
    end

    // Contention right after reset, then alternating grants with a 2-cycle gap.
    do_reset();
    bus.M0Req = 1'b1; bus.M1Req = 1'b1;
    bus.M0Ctrl = 9'h025; bus.M1Ctrl = 9'h00C;
    bus.BiuReady = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      automatic logic e1 = i[0];
      chk($sformatf("fair%0d m0gnt", i), bus.M0Gnt, !e1);
      chk($sformatf("fair%0d m1gnt", i), bus.M1Gnt, e1);
      chk($sformatf("fair%0d biuctrl", i), bus.BiuCtrl, e1 ? 9'h00C : 9'h025);
      if (e1) bus.M1Req = 1'b0; else bus.M0Req = 1'b0;
      step();
      chk($sformatf("fair%0d handover gnt", i), {bus.M1Gnt, bus.M0Gnt}, 2'b00);
      chk($sformatf("fair%0d handover en", i), bus.BiuEn, 1'b0);
      bus.M0Req = 1'b1; bus.M1Req = 1'b1;
      step();
      chk($sformatf("fair%0d idle gnt", i), {bus.M1Gnt, bus.M0Gnt}, 2'b00);
      step();
    end

    // Reset in the middle of an M1 CONT burst while the pointer favours M1.
    do_reset();
    bus.M0Req = 1'b1; bus.M0Ctrl = 9'h025;
    step();
    bus.M0Req = 1'b0; bus.BiuReady = 1'b1;
    step();
    step();
    bus.M1Req = 1'b1; bus.M1Ctrl = 9'h00C; bus.BiuReady = 1'b0;
    step();
    bus.M1Ctrl = 9'h08C;
    #1;
    chk("rstmid m1gnt", bus.M1Gnt, 1'b1);
    chk("rstmid biuctrl", bus.BiuCtrl, 9'h08C);
    Rst = 1'b1; bus.M0Req = 1'b1;
    step();
    chk("rstmid gnt", {bus.M1Gnt, bus.M0Gnt}, 2'b00);
    chk("rstmid biuen", bus.BiuEn, 1'b0);
    chk("rstmid biuctrl idle", bus.BiuCtrl, 9'h100);
    chk("rstmid biuaddr", bus.BiuAddr, 32'h0);
    Rst = 1'b0;
    step();
    chk("rstmid ptr m0gnt", bus.M0Gnt, 1'b1);
    chk("rstmid ptr m1gnt", bus.M1Gnt, 1'b0);

`ifdef ARB_WDOG_EN
    // Owner stuck in BUSY: released after 8 owned cycles, blocked until it drops Req.
    do_reset();
    bus.M0Req = 1'b1; bus.M0Ctrl = 9'h1A5;
    step();
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("wdog cyc%0d m0gnt", k), bus.M0Gnt, 1'b1);
      chk($sformatf("wdog cyc%0d err", k), bus.WdogErr, 1'b0);
      step();
    end
    chk("wdog release gnt", bus.M0Gnt, 1'b0);
    chk("wdog err set", bus.WdogErr, 1'b1);
    chk("wdog drain en", bus.BiuEn, 1'b1);
    chk("wdog drain ctrl", bus.BiuCtrl, 9'h125);
    bus.BiuReady = 1'b1;
    step();
    step();
    step();
    chk("wdog blocked gnt", bus.M0Gnt, 1'b0);
    bus.M0Req = 1'b0;
    step();
    bus.M0Req = 1'b1;
    step();
    chk("wdog regrant gnt", bus.M0Gnt, 1'b1);
    chk("wdog err sticky", bus.WdogErr, 1'b1);
    do_reset();
    chk("wdog err reset", bus.WdogErr, 1'b0);
`else
    // Without the watchdog a BUSY owner keeps the bus indefinitely.
    begin
      int held;
      held = 0;
      do_reset();
      bus.M0Req = 1'b1; bus.M0Ctrl = 9'h1A5; bus.M1Req = 1'b1;
      step();
      for (int k = 0; k < 70; k++) begin
        if (bus.M0Gnt === 1'b1 && bus.M1Gnt === 1'b0) held++;
        step();
      end
      chk("hold busy cycles", held, 70);
      chk("hold busy wdogerr", bus.WdogErr, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
